// File: rtl/mcdf_pkg.sv
// mcdf_pkg: command encodings, register map, cfg field layout and sequencer states
package mcdf_pkg;
  localparam logic [1:0] CMD_IDLE = 2'b00;
  localparam logic [1:0] CMD_WR   = 2'b10;
  localparam logic [1:0] CMD_RD   = 2'b01;
  localparam logic [5:0] ADDR_CH0 = 6'h00;
  localparam logic [5:0] ADDR_CH1 = 6'h04;
  localparam logic [5:0] ADDR_CH2 = 6'h08;
  localparam logic [5:0] ADDR_M0  = 6'h10;
  localparam logic [5:0] ADDR_M1  = 6'h14;
  localparam logic [5:0] ADDR_M2  = 6'h18;
  localparam int CFG_EN     = 0;
  localparam int CFG_PRIO   = 1;
  localparam int CFG_PKGLEN = 3;
  localparam int CFG_W      = 6;
  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_CHK, S_MRD, S_MCAP, S_DONE} state_t;
  function automatic logic [5:0] ch_addr(input logic [1:0] ch);
    return ch == 2'd0 ? ADDR_CH0 : ch == 2'd1 ? ADDR_CH1 : ADDR_CH2;
  endfunction
  function automatic logic [5:0] m_addr(input logic [1:0] mi);
    return mi == 2'd0 ? ADDR_M0 : mi == 2'd1 ? ADDR_M1 : ADDR_M2;
  endfunction
  function automatic logic [CFG_W-1:0] cfg_word(input logic [2:0] pkglen, input logic [1:0] prio, input logic en);
    return (CFG_W'(pkglen) << CFG_PKGLEN) | (CFG_W'(prio) << CFG_PRIO) | (CFG_W'(en) << CFG_EN);
  endfunction
endpackage

// File: rtl/mcdf_cfg_seq.sv
// mcdf_cfg_seq: writes three channel cfg registers, optionally reads them back, then snapshots FIFO margins
module mcdf_cfg_seq
  import mcdf_pkg::*;
#(
  parameter logic VERIFY_DEF = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic        verify_i,
  input  logic [5:0]  ch0_cfg_i,
  input  logic [5:0]  ch1_cfg_i,
  input  logic [5:0]  ch2_cfg_i,
  output logic [1:0]  cmd_o,
  output logic [5:0]  cmd_addr_o,
  output logic [31:0] cmd_data_o,
  input  logic [31:0] cmd_data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [1:0]  err_ch_o,
  output logic [5:0]  margin0_o,
  output logic [5:0]  margin1_o,
  output logic [5:0]  margin2_o
);
  state_t state, state_n;
  logic [1:0] ch, ch_n, mi, mi_n, cmd_n;
  logic [5:0] cfg0, cfg1, cfg2, sh0, sh1, cfg_cur, cfg_nxt, addr_n;
  logic [31:0] data_n;
  logic verify, start_ok, last, mismatch, unused_rd;
  assign start_ok = state == S_IDLE && start_i;
  assign last = ch == 2'd2;
  assign cfg_cur = ch == 2'd0 ? cfg0 : ch == 2'd1 ? cfg1 : cfg2;
  assign mismatch = state == S_CHK && cmd_data_i[CFG_W-1:0] != cfg_cur;
  assign mi_n = state == S_MRD ? mi + 2'd1 : 2'd0;
  assign unused_rd = ^cmd_data_i[31:CFG_W];
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      ch <= 2'd0;
      mi <= 2'd0;
    end else begin
      state <= state_n;
      ch <= ch_n;
      mi <= mi_n;
    end
  end
  always_comb begin
    state_n = state;
    ch_n = ch;
    case (state)
      S_IDLE:  state_n = start_i ? S_WR : S_IDLE;
      S_WR:    state_n = verify ? S_RD : last ? S_MRD : S_WR;
      S_RD:    state_n = S_CHK;
      S_CHK:   state_n = mismatch ? S_DONE : last ? S_MRD : S_WR;
      S_MRD:   state_n = mi == 2'd2 ? S_MCAP : S_MRD;
      S_MCAP:  state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase
    if (start_ok) ch_n = 2'd0;
    else if (state_n == S_WR && (state == S_WR || state == S_CHK)) ch_n = ch + 2'd1;
    if (abort_i && state != S_IDLE) state_n = S_IDLE;
  end
  // Outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    cmd_n = state_n == S_WR ? CMD_WR : (state_n == S_RD || state_n == S_MRD) ? CMD_RD : CMD_IDLE;
    addr_n = state_n == S_MRD ? m_addr(mi_n) : (state_n == S_WR || state_n == S_RD) ? ch_addr(ch_n) : 6'd0;
    cfg_nxt = start_ok ? ch0_cfg_i : ch_n == 2'd0 ? cfg0 : ch_n == 2'd1 ? cfg1 : cfg2;
    data_n = state_n == S_WR ? 32'(cfg_nxt) : 32'd0;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      verify <= VERIFY_DEF;
      {cfg0, cfg1, cfg2, sh0, sh1} <= '0;
      cmd_o <= CMD_IDLE;
      cmd_addr_o <= 6'd0;
      cmd_data_o <= 32'd0;
      {busy_o, done_o, err_o, err_ch_o} <= '0;
      {margin0_o, margin1_o, margin2_o} <= '0;
    end else begin
      cmd_o <= cmd_n;
      cmd_addr_o <= addr_n;
      cmd_data_o <= data_n;
      busy_o <= state_n != S_IDLE;
      done_o <= state_n == S_DONE;
      if (start_ok) begin
        {cfg0, cfg1, cfg2} <= {ch0_cfg_i, ch1_cfg_i, ch2_cfg_i};
        verify <= verify_i;
        err_o <= 1'b0;
        err_ch_o <= 2'd0;
      end
      if (state == S_CHK && state_n == S_DONE) begin
        err_o <= 1'b1;
        err_ch_o <= ch;
      end
      // Read data trails each margin RD by one cycle; the last word lands in MCAP.
      if (state == S_MRD && mi == 2'd1) sh0 <= cmd_data_i[CFG_W-1:0];
      if (state == S_MRD && mi == 2'd2) sh1 <= cmd_data_i[CFG_W-1:0];
      if (state == S_MCAP && state_n == S_DONE) {margin0_o, margin1_o, margin2_o} <= {sh0, sh1, cmd_data_i[CFG_W-1:0]};
    end
  end
endmodule

// File: tb/tb_mcdf_cfg_seq.sv
// tb_mcdf_cfg_seq: randomized scoreboard bench for the configuration sequencer
module tb_mcdf_cfg_seq;
  import mcdf_pkg::*;
  logic clk_i = 0, rst_i = 1, start_i = 0, abort_i = 0, verify_i = 0;
  logic [5:0] ch0_cfg_i = 0, ch1_cfg_i = 0, ch2_cfg_i = 0;
  logic [31:0] cmd_data_i = 0;
  logic [1:0] cmd_o, err_ch_o;
  logic [5:0] cmd_addr_o, margin0_o, margin1_o, margin2_o;
  logic [31:0] cmd_data_o;
  logic busy_o, done_o, err_o;
  mcdf_cfg_seq #(.VERIFY_DEF(1'b1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i), .verify_i(verify_i),
    .ch0_cfg_i(ch0_cfg_i), .ch1_cfg_i(ch1_cfg_i), .ch2_cfg_i(ch2_cfg_i),
    .cmd_o(cmd_o), .cmd_addr_o(cmd_addr_o), .cmd_data_o(cmd_data_o), .cmd_data_i(cmd_data_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_ch_o(err_ch_o),
    .margin0_o(margin0_o), .margin1_o(margin1_o), .margin2_o(margin2_o)
  );
  always #5 clk_i = ~clk_i;
  typedef struct {
    int cyc;
    bit dn;
    logic [1:0] cmd;
    logic [5:0] addr;
    logic [31:0] data;
    logic err;
    logic [1:0] ech;
    logic [5:0] m0, m1, m2;
  } ev_t;
  ev_t q[$];
  ev_t me;
  int cyc = 0, checks = 0, fails = 0;
  logic [5:0] wmem[4];
  logic [5:0] marg[3];
  logic [2:0] corrupt = 0;
  logic [31:0] r;
  logic [5:0] rd;
  logic e_err = 0;
  logic [1:0] e_ech = 0;
  logic [5:0] em0 = 0, em1 = 0, em2 = 0;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic ev_t mk(input int c, input logic [1:0] cmd, input logic [5:0] a, input logic [31:0] d);
    ev_t e;
    e = '{default: 0};
    e.cyc = c;
    e.cmd = cmd;
    e.addr = a;
    e.data = d;
    return e;
  endfunction
  always @(posedge clk_i) cyc <= cyc + 1;
  // Slave register file: stores writes, answers reads one cycle later, optionally corrupting cfg readback
  always @(posedge clk_i) begin
    r = $urandom();
    if (cmd_o == CMD_WR) wmem[cmd_addr_o[3:2]] <= cmd_data_o[5:0];
    rd = cmd_addr_o >= 6'h10 ? marg[cmd_addr_o[3:2]] : corrupt[cmd_addr_o[3:2]] ? 6'd0 : wmem[cmd_addr_o[3:2]];
    cmd_data_i <= cmd_o == CMD_RD ? {r[31:6], rd} : r;
  end
  always @(negedge clk_i) begin
    if (cmd_o != CMD_IDLE || done_o) begin
      if (q.size() == 0) chk("unexpected_output", {done_o, cmd_o, cmd_addr_o}, 0);
      else begin
        me = q.pop_front();
        chk("event_cycle", cyc, me.cyc);
        if (me.dn) chk("done_payload", {done_o, cmd_o, err_o, err_ch_o, margin0_o, margin1_o, margin2_o},
                       {1'b1, CMD_IDLE, me.err, me.ech, me.m0, me.m1, me.m2});
        else chk("cmd_payload", {done_o, cmd_o, cmd_addr_o, cmd_data_o}, {1'b0, me.cmd, me.addr, me.data});
      end
    end
  end
  task automatic run(input logic [5:0] c0, c1, c2, input logic ver, input logic [2:0] bad,
                     input logic [5:0] m0, m1, m2, input int cut, input int sp, input bit rmode, input bit ab0);
    logic [5:0] cf[3];
    int t, base, endc, j;
    bit er;
    logic [1:0] ec;
    ev_t e;
    ev_t lq[$];
    cf = '{c0, c1, c2};
    t = 1;
    er = 0;
    ec = 0;
    for (int c = 0; c < 3 && !er; c++) begin
      lq.push_back(mk(t, CMD_WR, 6'(4 * c), 32'(cf[c])));
      t++;
      if (ver) begin
        lq.push_back(mk(t, CMD_RD, 6'(4 * c), 0));
        t += 2;
        if (bad[c] && cf[c] != 0) begin
          er = 1;
          ec = 2'(c);
        end
      end
    end
    if (!er) begin
      for (int i = 0; i < 3; i++) lq.push_back(mk(t + i, CMD_RD, 6'(16 + 4 * i), 0));
      t += 4;
    end
    if (cut >= t) cut = 0;
    if (sp == 1 && cut == 1) sp = 0;
    e_err = cut == 0 ? er : 1'b0;
    e_ech = cut == 0 ? ec : 2'd0;
    if (cut == 0 && !er) {em0, em1, em2} = {m0, m1, m2};
    if (cut == 0) begin
      e = mk(t, CMD_IDLE, 0, 0);
      e.dn = 1;
      e.err = e_err;
      e.ech = e_ech;
      {e.m0, e.m1, e.m2} = {em0, em1, em2};
      lq.push_back(e);
    end
    @(negedge clk_i);
    {ch0_cfg_i, ch1_cfg_i, ch2_cfg_i} = {c0, c1, c2};
    verify_i = ver;
    corrupt = bad;
    marg = '{m0, m1, m2};
    start_i = 1;
    abort_i = ab0;
    base = cyc;
    foreach (lq[k]) if (cut == 0 || lq[k].cyc <= cut) begin
      e = lq[k];
      e.cyc += base;
      q.push_back(e);
    end
    endc = cut != 0 ? cut + 1 : t + 1;
    for (j = 1; j <= 40; j++) begin
      @(negedge clk_i);
      if (j == 1) begin
        {ch0_cfg_i, ch1_cfg_i, ch2_cfg_i} = 18'($urandom());
        verify_i = 1'($urandom());
      end
      start_i = (sp == 1 && j == 2) || (sp == 2 && j >= 2 && j <= cut);
      abort_i = !rmode && j == cut;
      rst_i = rmode && j == cut;
      if (!busy_o) break;
    end
    chk("run_length", j, endc);
    start_i = 0;
    abort_i = 0;
    rst_i = 0;
    if (rmode) begin
      chk("reset_outputs", {cmd_o, cmd_addr_o, cmd_data_o, busy_o, done_o, err_o, err_ch_o, margin0_o, margin1_o, margin2_o}, 0);
      {e_err, e_ech, em0, em1, em2} = '0;
    end
    chk("status", {err_o, err_ch_o, margin0_o, margin1_o, margin2_o}, {e_err, e_ech, em0, em1, em2});
    @(negedge clk_i);
    chk("queue_drained", q.size(), 0);
    q.delete();
  endtask
  function automatic logic [5:0] rcfg();
    return cfg_word(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
  endfunction
  initial begin
    repeat (3) @(negedge clk_i);
    chk("reset_state", {cmd_o, cmd_addr_o, cmd_data_o, busy_o, done_o, err_o, err_ch_o, margin0_o, margin1_o, margin2_o}, 0);
    rst_i = 0;
    @(negedge clk_i);
    run(6'h01, 6'h0B, 6'h3F, 0, 3'b000, 6'd5, 6'd6, 6'd7, 0, 1, 0, 0);
    run(rcfg(), rcfg(), rcfg(), 1, 3'b000, 6'd32, 6'd16, 6'd8, 0, 0, 0, 0);
    run(6'h01, 6'h0B, 6'h3F, 1, 3'b010, 6'd1, 6'd2, 6'd3, 0, 0, 0, 0);
    run(6'h11, 6'h22, 6'h33, 0, 3'b000, 6'd9, 6'd9, 6'd9, 2, 0, 0, 0);
    run(6'h21, 6'h12, 6'h0C, 0, 3'b000, 6'd4, 6'd5, 6'd6, 0, 0, 0, 1);
    for (int n = 0; n < 30; n++)
      run(rcfg(), rcfg(), rcfg(), 1'($urandom()), 3'($urandom()), 6'($urandom()), 6'($urandom()), 6'($urandom()),
          $urandom_range(0, 2) == 0 ? $urandom_range(1, 14) : 0, $urandom_range(0, 1), 0, 1'($urandom()));
    run(6'h07, 6'h19, 6'h2A, 0, 3'b000, 6'd11, 6'd12, 6'd13, 5, 2, 1, 0);
    run(6'h07, 6'h19, 6'h2A, 1, 3'b000, 6'd21, 6'd22, 6'd23, 0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/mcdf_cfg_seq.md
MCDF_CFG_SEQ -- requirements
Module: mcdf_cfg_seq

Interface
REQ-001 Parameter VERIFY_DEF, default 1'b1: reset value of the internal verify-enable latch.
REQ-002 clk_i  in  1  single clock, all logic rising-edge.
REQ-003 rst_i  in  1  reset, synchronous, active-high.
REQ-004 start_i  in  1  request one configuration run; sampled only in IDLE.
REQ-005 abort_i  in  1  terminate any run in progress.
REQ-006 verify_i  in  1  read back each written slave register; latched at accepted start.
REQ-007 ch0_cfg_i / ch1_cfg_i / ch2_cfg_i  in  6 each  {pkglen[2:0], prio[1:0], en}; latched at accepted start.
REQ-008 cmd_o  out  2  register command: 2'b00 IDLE, 2'b10 WR, 2'b01 RD.
REQ-009 cmd_addr_o  out  6  register address.
REQ-010 cmd_data_o  out  32  write data, {26'b0, cfg[5:0]}; zero when cmd_o is not WR.
REQ-011 cmd_data_i  in  32  read data from control register, valid the cycle after an RD.
REQ-012 busy_o  out  1  high in every non-IDLE state.
REQ-013 done_o  out  1  one-cycle pulse at run completion (normal or error).
REQ-014 err_o  out  1  readback mismatch flag; held until next accepted start or reset.
REQ-015 err_ch_o  out  2  channel index of the first mismatch.
REQ-016 margin0_o / margin1_o / margin2_o  out  6 each  FIFO margin snapshot of the last successful run.

Function
REQ-017 FSM states: IDLE, WR, RD, CHK, MRD, MCAP, DONE; channel counter ch[1:0] (0..2) and margin read index mi[1:0].
REQ-018 In IDLE, start_i=1 latches the cfg inputs and verify_i, clears err_o/err_ch_o, sets ch=0, and enters WR.
REQ-019 WR drives cmd_o=WR, addr = 0x00/0x04/0x08 for ch 0/1/2, data = latched cfg; next state RD if verify else (ch<2 ? WR with ch+1 : MRD).
REQ-020 RD drives RD to the same address; next CHK with cmd_o=IDLE.
REQ-021 CHK compares cmd_data_i[5:0] to the latched cfg; on a match it proceeds as WR does without verify; on a mismatch it sets err_o=1, err_ch_o=ch, and enters DONE.
REQ-022 MRD issues RD to 0x10, 0x14, 0x18 on three consecutive cycles; cmd_data_i[5:0] is captured into a shadow the cycle after each RD; MCAP captures the final word.
REQ-023 Margin outputs update together from the shadows on DONE entry, only when err_o=0.
REQ-024 DONE pulses done_o for one cycle, then returns to IDLE; busy_o falls in the same cycle.
REQ-025 Latency without verify: start sampled at edge N, writes in cycles N+1..N+3, reads N+4..N+6, done_o=1 in cycle N+8.
REQ-026 Latency with verify: writes and checks occupy N+1..N+9, margin reads N+10..N+12, done_o=1 in cycle N+14.
REQ-027 start_i while busy_o=1 is ignored.
REQ-028 abort_i=1 in any non-IDLE state forces IDLE next cycle with cmd_o=IDLE; no done_o; margins and err unchanged.
REQ-029 abort_i and start_i both high in IDLE: start wins.
REQ-030 cmd_o is never WR or RD in IDLE, CHK, MCAP, or DONE.

Reset
REQ-031 rst_i=1 at an edge: state IDLE, cmd_o=00, cmd_addr_o=0, cmd_data_o=0, busy_o=0, done_o=0, err_o=0, err_ch_o=0, margins=0, verify latch=VERIFY_DEF.
REQ-032 Reset mid-run takes priority over abort and over every state transition.

Structure
REQ-033 The shared mcdf_pkg holds the command encodings, the register addresses (0x00/04/08/10/14/18), the cfg field offsets, and the FSM state typedef.
REQ-034 The block is a single module with no sub-modules; all outputs are registered.

Verification
REQ-035 verify=0, cfg 0x01/0x0B/0x3F, start -> WR 0x00=0x01, WR 0x04=0x0B, WR 0x08=0x3F in cycles N+1..N+3; done_o at N+8.
REQ-036 verify=1, model echoes writes; margins return 32/16/8 -> margin0/1/2_o = 32/16/8; err_o=0; done_o at N+14.
REQ-037 verify=1, model corrupts the ch1 readback (returns 0x00 for 0x0B) -> err_o=1, err_ch_o=1; no WR to 0x08; done_o pulses; margins unchanged.
REQ-038 abort_i during the second WR -> cmd_o=IDLE next cycle, busy_o=0, no done_o; next start runs cleanly.
REQ-039 rst_i asserted during MRD -> all outputs reach reset values at the next edge; start_i held high during the run is ignored.
